// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/memory handshake bundle between sequencer and datapath
interface multicycle_ctrl_if;
   logic        run;
   logic [5:0]  opCode;
   logic [5:0]  fnCode;
   logic        zero;
   logic        mem_ready;
   logic        mem_read;
   logic        mem_write;
   logic        i_or_d;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        alu_src;
   logic [2:0]  op;
   logic        reg_dst;
   logic        reg_write;
   logic        mem2reg;
   logic        halted;
   logic [31:0] inst_count;

   modport master (
      input  run, opCode, fnCode, zero, mem_ready,
      output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             alu_src, op, reg_dst, reg_write, mem2reg, halted, inst_count
   );

   modport slave (
      output run, opCode, fnCode, zero, mem_ready,
      input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             alu_src, op, reg_dst, reg_write, mem2reg, halted, inst_count
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-subset control sequencer with shared memory port and retire counter
module multicycle_ctrl (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t      state, nxt, ret_st;
   logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, r_ok, legal, retire;
   logic [2:0]  r_op, alu_op;
   logic [31:0] cnt;
   logic        halted_q, mem_read_q, mem_write_q, i_or_d_q, alu_src_q;
   logic        reg_dst_q, reg_write_q, mem2reg_q;
   logic [1:0]  pc_src_q;
   logic [2:0]  op_q;
   logic        fetch_ok;

   // decode the IR fields into instruction classes and the ALU operation
   always_comb begin
      is_r    = bus.opCode == 6'h00;
      is_addi = bus.opCode == 6'h08;
      is_lw   = bus.opCode == 6'h23;
      is_sw   = bus.opCode == 6'h2b;
      is_beq  = bus.opCode == 6'h04;
      is_j    = bus.opCode == 6'h02;
      r_ok    = bus.fnCode inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      r_op    = bus.fnCode == 6'h20 ? 3'b010 :
                bus.fnCode == 6'h22 ? 3'b110 :
                bus.fnCode == 6'h24 ? 3'b000 :
                bus.fnCode == 6'h25 ? 3'b001 : 3'b111;
      legal   = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;
      alu_op  = is_r ? r_op : is_beq ? 3'b110 : 3'b010;
   end

   // next state and the retire strobe on the last state of each instruction
   always_comb begin
      ret_st = bus.run ? FETCH : IDLE;
      nxt    = state;
      retire = 1'b0;
      case (state)
         IDLE:   nxt = bus.run ? FETCH : IDLE;
         FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            nxt    = !legal ? HALT : is_j ? ret_st : EXEC;
            retire = is_j;
         end
         EXEC: begin
            nxt    = is_beq ? ret_st : (is_lw || is_sw) ? MEM : WB;
            retire = is_beq;
         end
         MEM: begin
            nxt    = !bus.mem_ready ? MEM : is_sw ? ret_st : WB;
            retire = bus.mem_ready && is_sw;
         end
         WB: begin
            nxt    = ret_st;
            retire = 1'b1;
         end
         default: nxt = HALT;
      endcase
   end

   // state, sticky halt, retire counter, and Moore outputs registered for the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         halted_q    <= 1'b0;
         cnt         <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_or_d_q    <= 1'b0;
         alu_src_q   <= 1'b0;
         op_q        <= 3'b000;
         pc_src_q    <= 2'd0;
         reg_dst_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem2reg_q   <= 1'b0;
      end else begin
         state       <= nxt;
         halted_q    <= halted_q || (state == DECODE && !legal);
         cnt         <= cnt + 32'(retire);
         mem_read_q  <= nxt == FETCH || (nxt == MEM && is_lw);
         mem_write_q <= nxt == MEM && is_sw;
         i_or_d_q    <= nxt == MEM;
         alu_src_q   <= (nxt == EXEC && (is_addi || is_lw || is_sw)) || nxt == MEM ||
                        (nxt == WB && is_addi);
         op_q        <= nxt == EXEC ? alu_op :
                        (nxt == MEM || (nxt == WB && is_addi)) ? 3'b010 : 3'b000;
         pc_src_q    <= nxt == EXEC && is_beq ? 2'd1 : 2'd0;
         reg_dst_q   <= nxt == WB && is_r;
         reg_write_q <= nxt == WB;
         mem2reg_q   <= nxt == WB && is_lw;
      end
   end

   // Mealy strobes: fetch completion, jump in decode, taken branch in exec
   always_comb begin
      fetch_ok     = state == FETCH && bus.mem_ready;
      bus.ir_write = fetch_ok;
      bus.pc_write = fetch_ok || (state == DECODE && is_j) || (state == EXEC && is_beq && bus.zero);
      bus.pc_src   = state == DECODE && is_j ? 2'd2 : pc_src_q;
   end

   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.i_or_d     = i_or_d_q;
   assign bus.alu_src    = alu_src_q;
   assign bus.op         = op_q;
   assign bus.reg_dst    = reg_dst_q;
   assign bus.reg_write  = reg_write_q;
   assign bus.mem2reg    = mem2reg_q;
   assign bus.halted     = halted_q;
   assign bus.inst_count = cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed cycle-by-cycle check of the control sequencer outputs
module tb_multicycle_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_run  = 0;
   int   n_fail = 0;

   multicycle_ctrl_if bus ();
   multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // fields: {mem_read mem_write i_or_d}_{ir_write pc_write}_{pc_src}_{alu_src}_{op}_{reg_dst reg_write mem2reg}_{halted}
   localparam logic [14:0] V0    = 15'b000_00_00_0_000_000_0;
   localparam logic [14:0] FW    = 15'b100_00_00_0_000_000_0;
   localparam logic [14:0] FOK   = 15'b100_11_00_0_000_000_0;
   localparam logic [14:0] DJ    = 15'b000_01_10_0_000_000_0;
   localparam logic [14:0] EADD  = 15'b000_00_00_0_010_000_0;
   localparam logic [14:0] ESLT  = 15'b000_00_00_0_111_000_0;
   localparam logic [14:0] WBR   = 15'b000_00_00_0_000_110_0;
   localparam logic [14:0] EIMM  = 15'b000_00_00_1_010_000_0;
   localparam logic [14:0] WADDI = 15'b000_00_00_1_010_010_0;
   localparam logic [14:0] MLW   = 15'b101_00_00_1_010_000_0;
   localparam logic [14:0] MSW   = 15'b011_00_00_1_010_000_0;
   localparam logic [14:0] WLW   = 15'b000_00_00_0_000_011_0;
   localparam logic [14:0] EB1   = 15'b000_01_01_0_110_000_0;
   localparam logic [14:0] EB0   = 15'b000_00_01_0_110_000_0;
   localparam logic [14:0] HV    = 15'b000_00_00_0_000_000_1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] obs();
      return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.alu_src, bus.op, bus.reg_dst, bus.reg_write, bus.mem2reg, bus.halted};
   endfunction

   task automatic cyc(input string tag, input logic [14:0] exp, input logic rdy, input logic z);
      bus.mem_ready = rdy;
      bus.zero      = z;
      #1 chk(tag, 32'(obs()), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic setins(input logic [5:0] o, input logic [5:0] f);
      bus.opCode = o;
      bus.fnCode = f;
   endtask

   initial begin
      bus.run = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      setins(6'h00, 6'h00);
      #2 chk("rst_out", 32'(obs()), 32'(V0));
      chk("rst_cnt", bus.inst_count, 32'd0);
      #6 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("idle_cnt", bus.inst_count, 32'd0);
         cyc("idle", V0, 1'b1, 1'b0);
      end
      bus.run = 1'b1;
      cyc("go_idle", V0, 1'b1, 1'b0);
      setins(6'h00, 6'h20);
      cyc("add_f", FOK, 1'b1, 1'b0); cyc("add_d", V0, 1'b1, 1'b0);
      cyc("add_e", EADD, 1'b1, 1'b0); cyc("add_w", WBR, 1'b1, 1'b0);
      chk("add_cnt", bus.inst_count, 32'd1);
      setins(6'h00, 6'h2a);
      cyc("slt_f", FOK, 1'b1, 1'b0); cyc("slt_d", V0, 1'b1, 1'b0);
      cyc("slt_e", ESLT, 1'b1, 1'b0); cyc("slt_w", WBR, 1'b1, 1'b0);
      chk("slt_cnt", bus.inst_count, 32'd2);
      setins(6'h08, 6'h00);
      cyc("addi_f", FOK, 1'b1, 1'b0); cyc("addi_d", V0, 1'b1, 1'b0);
      cyc("addi_e", EIMM, 1'b1, 1'b0); cyc("addi_w", WADDI, 1'b1, 1'b0);
      chk("addi_cnt", bus.inst_count, 32'd3);
      setins(6'h23, 6'h00);
      cyc("lw_f", FOK, 1'b1, 1'b0); cyc("lw_d", V0, 1'b1, 1'b0); cyc("lw_e", EIMM, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("lw_mwait", MLW, 1'b0, 1'b0);
      cyc("lw_m", MLW, 1'b1, 1'b0); cyc("lw_w", WLW, 1'b1, 1'b0);
      chk("lw_cnt", bus.inst_count, 32'd4);
      setins(6'h04, 6'h00);
      cyc("beq1_f", FOK, 1'b1, 1'b1); cyc("beq1_d", V0, 1'b1, 1'b1); cyc("beq1_e", EB1, 1'b1, 1'b1);
      chk("beq1_cnt", bus.inst_count, 32'd5);
      cyc("beq0_f", FOK, 1'b1, 1'b0); cyc("beq0_d", V0, 1'b1, 1'b0); cyc("beq0_e", EB0, 1'b1, 1'b0);
      chk("beq0_cnt", bus.inst_count, 32'd6);
      setins(6'h02, 6'h00);
      cyc("j_f", FOK, 1'b1, 1'b0); cyc("j_d", DJ, 1'b1, 1'b0);
      chk("j_cnt", bus.inst_count, 32'd7);
      cyc("jw_fw0", FW, 1'b0, 1'b0); cyc("jw_fw1", FW, 1'b0, 1'b0);
      cyc("jw_f", FOK, 1'b1, 1'b0); cyc("jw_d", DJ, 1'b1, 1'b0);
      chk("jw_cnt", bus.inst_count, 32'd8);
      setins(6'h2b, 6'h00);
      cyc("sw_f", FOK, 1'b1, 1'b0); cyc("sw_d", V0, 1'b1, 1'b0);
      bus.run = 1'b0;
      cyc("sw_e", EIMM, 1'b1, 1'b0); cyc("sw_m", MSW, 1'b1, 1'b0);
      chk("sw_cnt", bus.inst_count, 32'd9);
      cyc("sw_idle0", V0, 1'b1, 1'b0); cyc("sw_idle1", V0, 1'b1, 1'b0);
      force dut.cnt = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.cnt;
      chk("wrap_pre", bus.inst_count, 32'hFFFF_FFFF);
      setins(6'h02, 6'h00);
      bus.run = 1'b1;
      cyc("wrap_idle", V0, 1'b1, 1'b0); cyc("wrap_f", FOK, 1'b1, 1'b0);
      bus.run = 1'b0;
      cyc("wrap_d", DJ, 1'b1, 1'b0);
      chk("wrap_cnt", bus.inst_count, 32'd0);
      cyc("wrap_idle2", V0, 1'b1, 1'b0);
      bus.run = 1'b1;
      cyc("j2_idle", V0, 1'b1, 1'b0); cyc("j2_f", FOK, 1'b1, 1'b0); cyc("j2_d", DJ, 1'b1, 1'b0);
      chk("j2_cnt", bus.inst_count, 32'd1);
      setins(6'h3f, 6'h00);
      cyc("ill_f", FOK, 1'b1, 1'b0); cyc("ill_d", V0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cyc("halt", HV, 1'(i % 2), 1'(i % 3 == 0));
      chk("halt_cnt", bus.inst_count, 32'd1);
      rst_n = 1'b0;
      #1 chk("hrst", 32'(obs()), 32'(V0));
      rst_n = 1'b1;
      cyc("hrst_idle", V0, 1'b0, 1'b0);
      cyc("rf_w", FW, 1'b0, 1'b0);
      #1 chk("rf_hold", 32'(obs()), 32'(FW));
      rst_n = 1'b0;
      #1 chk("rf_rst", 32'(obs()), 32'(V0));
      chk("rf_cnt", bus.inst_count, 32'd0);
      bus.run = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc("rf_idle", V0, 1'b1, 1'b0);
      setins(6'h00, 6'h21);
      bus.run = 1'b1;
      cyc("rill_idle", V0, 1'b1, 1'b0); cyc("rill_f", FOK, 1'b1, 1'b0); cyc("rill_d", V0, 1'b1, 1'b0);
      cyc("rill_h", HV, 1'b1, 1'b0);
      chk("rill_cnt", bus.inst_count, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath (fetch, decode, execute, data memory, write-back). It replaces the per-instruction combinational control (yC1–yC4) with a state machine, so one shared, variable-latency memory port serves both instruction fetch and data access. Each instruction is spread over 2–5 states. The block also drives PC/IR write enables and keeps a retired-instruction counter.

## Interface
- No parameters. Opcode and function encodings are fixed in the Operation section.
- clk  in  1  system clock; all state changes occur on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- opCode  in  6  ins[31:26] taken from the datapath IR.
- fnCode  in  6  ins[5:0] taken from the datapath IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  shared memory has completed the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result z.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC from the pc_src mux.
- pc_src  out  2  PC mux select: 0 = PC+4, 1 = PC+4+(imm<<2), 2 = jump target.
- alu_src  out  1  ALU operand B select: 0 = rd2, 1 = imm.
- op  out  3  ALU operation (same encoding as yEX).
- reg_dst  out  1  destination register: 1 = rd (R-type), 0 = rt.
- reg_write  out  1  register file write enable.
- mem2reg  out  1  write-back data select: 1 = memOut, 0 = z.
- halted  out  1  sticky flag; set on an illegal opcode.
- inst_count  out  32  number of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. The state register is the only sequential control state besides halted and inst_count.
- Supported opcodes:
  - 0x00 R-type; fnCode selects op: 0x20 add→010, 0x22 sub→110, 0x24 and→000, 0x25 or→001, 0x2a slt→111.
  - 0x08 addi, 0x23 lw, 0x2b sw: op 010.
  - 0x04 beq: op 110.
  - 0x02 j.
- Output defaults: every output not listed for the current state is 0.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - Drive mem_read=1, i_or_d=0.
  - While mem_ready=0: hold all outputs and stay in FETCH.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE:
  - j: pc_write=1, pc_src=2; the instruction retires; go to FETCH, or IDLE if run=0.
  - Illegal opcode, or R-type with an unlisted fnCode: go to HALT, set halted. inst_count does not change.
  - All other opcodes: go to EXEC.
- EXEC: drive op per the table. alu_src=1 for addi, lw and sw.
  - beq: pc_write=zero (combinational, Mealy output), pc_src=1; the instruction retires; go to FETCH/IDLE.
  - R-type, addi: go to WB.
  - lw, sw: go to MEM.
- MEM:
  - Drive i_or_d=1, op=010, alu_src=1.
  - lw: mem_read=1. sw: mem_write=1.
  - Hold until mem_ready=1.
  - sw retires on that cycle and goes to FETCH/IDLE. lw goes to WB.
- WB:
  - reg_write=1.
  - reg_dst=1 for R-type.
  - mem2reg=1 for lw; op=010 and alu_src=1 are held for addi.
  - The instruction retires; go to FETCH/IDLE.
- Retire: inst_count increments by 1 on the clock edge that leaves the final state of an instruction. It wraps from 0xFFFFFFFF to 0.
- run: sampled only at retire boundaries and in IDLE. A run=0 mid-instruction never aborts the instruction.
- HALT: absorbing state with all strobes 0. Only rst_n leaves it.

## Timing
- Reset values: state=IDLE, all strobes 0, pc_src=0, op=000, halted=0, inst_count=0.
- Reset takes effect immediately and asynchronously, including mid-access; mem_read and mem_write drop without waiting for a clock edge.
- Cycles per instruction, with mem_ready=1 on every first request cycle:
  - j: 2
  - beq: 3
  - sw: 4
  - R-type, addi: 4
  - lw: 5
- Each memory wait cycle adds 1 cycle.
- Memory handshake: a request is held stable until the cycle in which mem_ready=1 is seen. mem_ready is ignored when no request is driven.
- Strobe behaviour:
  - All strobes are single-cycle pulses, except requests stretched by memory wait.
  - ir_write and pc_write are never both asserted outside FETCH.
  - At most one of mem_read / mem_write is 1 in any cycle.

## Test plan
- Reset/idle: hold rst_n=0, then release with run=0 for 5 cycles → state stays IDLE, all outputs 0, inst_count=0. Then set run=1 → mem_read=1, i_or_d=0 on the next cycle.
- R-type add (0x00, fn 0x20) with mem_ready always 1 → exactly 4 cycles. WB cycle shows reg_write=1, reg_dst=1, mem2reg=0. inst_count goes 0→1. Repeat with fn 0x2a and check op=111 in EXEC.
- lw (0x23) with mem_ready delayed 3 cycles in MEM → i_or_d=1 and mem_read=1 held stable for 4 cycles. WB shows mem2reg=1, reg_dst=0. Total 8 cycles.
- beq (0x04):
  - with zero=1 → EXEC shows pc_write=1, pc_src=1; 3 cycles total.
  - with zero=0 → pc_write=0; the instruction still retires.
- Boundaries:
  - j → DECODE shows pc_write=1, pc_src=2.
  - Opcode 0x3f → HALT, halted=1, inst_count unchanged, no further strobes after 20 cycles.
  - run=0 asserted during EXEC of sw → the sw completes (mem_write pulse), then IDLE.
  - rst_n pulsed low during a FETCH wait → mem_read=0 immediately, IDLE.
- Counter wrap: preload via 2^32 retires, or force inst_count=0xFFFFFFFF and retire one j → inst_count=0.
